// File: rtl/instr_encoder.sv
// Purpose: encodes one LEGv8 instruction description per request into a 32-bit word for instruction memory.
// Latency: 1 cycle from an accepted legal request to wr_valid.
// Backpressure: the word is held stable until wr_ready; no new request is taken while holding or full.
//
// Ports:
//   clk, reset_n (async active-low), clear (synchronous restart)
//   in_valid/in_ready, in_sel, in_rd/in_rn/in_rm, in_imm  : request side
//   wr_valid/wr_ready, wr_data, wr_addr                   : instruction-memory write side
//   count, full, err                                      : status
module instr_encoder #(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int          DEPTH     = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_sel,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rn,
    input  logic [4:0]  in_rm,
    input  logic [63:0] in_imm,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [31:0] wr_data,
    output logic [63:0] wr_addr,
    output logic [6:0]  count,
    output logic        full,
    output logic        err
);

    localparam logic [6:0] DEPTH_C = 7'(DEPTH);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [63:0] wr_addr_q, wr_addr_d;
    logic [6:0]  count_q, count_d;
    logic        err_q, err_d;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;
    logic        wr_fire;

    // Sign extensions of the immediate widths each format can carry; a value is
    // in range exactly when it survives truncation to that width.
    logic [63:0] sext9, sext21, sext28;
    assign sext9  = {{55{in_imm[8]}},  in_imm[8:0]};
    assign sext21 = {{43{in_imm[20]}}, in_imm[20:0]};
    assign sext28 = {{36{in_imm[27]}}, in_imm[27:0]};

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b0;
        case (in_sel)
            4'd0: begin enc_word = {11'b10001011000, in_rm, 6'b0, in_rn, in_rd}; enc_legal = 1'b1; end
            4'd1: begin enc_word = {11'b11001011000, in_rm, 6'b0, in_rn, in_rd}; enc_legal = 1'b1; end
            4'd2: begin enc_word = {11'b10001010000, in_rm, 6'b0, in_rn, in_rd}; enc_legal = 1'b1; end
            4'd3: begin enc_word = {11'b10101010000, in_rm, 6'b0, in_rn, in_rd}; enc_legal = 1'b1; end
            4'd4: begin
                enc_word  = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
                enc_legal = (in_imm == sext9);
            end
            4'd5: begin
                enc_word  = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
                enc_legal = (in_imm == sext9);
            end
            4'd6: begin
                enc_word  = {10'b1001000100, in_imm[11:0], in_rn, in_rd};
                enc_legal = (in_imm[63:12] == 52'h0);
            end
            4'd7: begin
                enc_word  = {10'b1101000100, in_imm[11:0], in_rn, in_rd};
                enc_legal = (in_imm[63:12] == 52'h0);
            end
            4'd8: begin
                enc_word  = {8'b10110100, in_imm[20:2], in_rd};
                enc_legal = (in_imm[1:0] == 2'b00) && (in_imm == sext21);
            end
            4'd9: begin
                enc_word  = {6'b000101, in_imm[27:2]};
                enc_legal = (in_imm[1:0] == 2'b00) && (in_imm == sext28);
            end
            default: begin enc_word = 32'h0; enc_legal = 1'b0; end
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign wr_fire = wr_valid && wr_ready;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; clear overrides any handshake and drops a held word.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept && enc_legal) state_d = HOLD;
                HOLD:    if (wr_ready)            state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        in_ready = (state_q == IDLE) && !full;
        wr_valid = (state_q == HOLD);
    end

    // Datapath next-state
    always_comb begin
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;
        count_d   = count_q;
        err_d     = err_q;
        if (clear) begin
            wr_data_d = 32'h0;
            wr_addr_d = BASE_ADDR;
            count_d   = 7'd0;
            err_d     = 1'b0;
        end else begin
            // A rejected request still completes its handshake; it only leaves err behind.
            if (accept) begin
                if (enc_legal) wr_data_d = enc_word;
                else           err_d     = 1'b1;
            end
            if (wr_fire) begin
                wr_addr_d = wr_addr_q + 64'd4;
                count_d   = count_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_data_q <= 32'h0;
            wr_addr_q <= BASE_ADDR;
            count_q   <= 7'd0;
            err_q     <= 1'b0;
        end else begin
            wr_data_q <= wr_data_d;
            wr_addr_q <= wr_addr_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    assign wr_data = wr_data_q;
    assign wr_addr = wr_addr_q;
    assign count   = count_q;
    assign full    = (count_q == DEPTH_C);
    assign err     = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Purpose: scoreboard bench for instr_encoder; random and directed requests against a reference encoder.
// Latency: expected words are queued at request acceptance and popped when the DUT writes.
// Backpressure: wr_ready is driven always-high, random, or held low depending on the phase.
module tb_instr_encoder;

    localparam logic [63:0] BASE = 64'h1000;
    localparam int          DEP  = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_sel = 4'd0;
    logic [4:0]  in_rd = 5'd0, in_rn = 5'd0, in_rm = 5'd0;
    logic [63:0] in_imm = 64'd0;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [31:0] wr_data;
    logic [63:0] wr_addr;
    logic [6:0]  count;
    logic        full;
    logic        err;

    instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEP)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_addr(wr_addr),
        .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [63:0] addr;
        int          sel;
        longint      imm;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     failures = 0;
    int     pushed = 0;      // words the model expects since reset/clear
    logic   err_exp = 1'b0;
    int     rdy_mode = 0;    // 0 always ready, 1 random, 2 held low

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: legality from plain integer ranges.
    function automatic bit model_legal(int sel, longint imm);
        case (sel)
            0, 1, 2, 3: return 1'b1;
            4, 5:       return (imm >= -256) && (imm <= 255);
            6, 7:       return (imm >= 0) && (imm <= 4095);
            8:          return (imm % 4 == 0) && (imm >= -(64'sd1 <<< 20)) && (imm < (64'sd1 <<< 20));
            9:          return (imm % 4 == 0) && (imm >= -(64'sd1 <<< 27)) && (imm < (64'sd1 <<< 27));
            default:    return 1'b0;
        endcase
    endfunction

    // Reference: field placement by weighted sums of opcode and operands.
    function automatic logic [31:0] model_enc(int sel, int rd, int rn, int rm, longint imm);
        longint w;
        longint rop[4] = '{'h458, 'h658, 'h450, 'h550};
        w = 0;
        case (sel)
            0, 1, 2, 3: w = rop[sel] * (64'sd1 <<< 21) + rm * 65536 + rn * 32 + rd;
            4:          w = 'h7C2 * (64'sd1 <<< 21) + (imm & 511) * 4096 + rn * 32 + rd;
            5:          w = 'h7C0 * (64'sd1 <<< 21) + (imm & 511) * 4096 + rn * 32 + rd;
            6:          w = 'h244 * (64'sd1 <<< 22) + imm * 1024 + rn * 32 + rd;
            7:          w = 'h344 * (64'sd1 <<< 22) + imm * 1024 + rn * 32 + rd;
            8:          w = 180 * (64'sd1 <<< 24) + ((imm / 4) & ((64'sd1 <<< 19) - 1)) * 32 + rd;
            9:          w = 5 * (64'sd1 <<< 26) + ((imm / 4) & ((64'sd1 <<< 26) - 1));
            default:    w = 0;
        endcase
        return w[31:0];
    endfunction

    // Decode-side immediate extension of an emitted word.
    function automatic longint decode_imm(int sel, logic [31:0] w);
        longint v;
        v = 0;
        case (sel)
            4, 5: begin v = longint'(w[20:12]); if (v >= 256) v -= 512; end
            6, 7: v = longint'(w[21:10]);
            8:    begin v = longint'(w[23:5]); if (v >= (64'sd1 <<< 18)) v -= (64'sd1 <<< 19); v *= 4; end
            9:    begin v = longint'(w[25:0]); if (v >= (64'sd1 <<< 25)) v -= (64'sd1 <<< 26); v *= 4; end
            default: v = 0;
        endcase
        return v;
    endfunction

    // wr_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = 1'($urandom_range(0, 1));
                default: wr_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops expected words on each write handshake and checks hold stability.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        logic [63:0] prev_addr;
        exp_t        e;
        prev_stall = 1'b0;
        prev_data  = 32'h0;
        prev_addr  = 64'h0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (wr_valid && prev_stall) begin
                    check("hold_data_stable", {32'h0, wr_data}, {32'h0, prev_data});
                    check("hold_addr_stable", wr_addr, prev_addr);
                end
                if (wr_valid && wr_ready) begin
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_write: data 0x%0h with empty scoreboard", wr_data);
                    end else begin
                        e = sb.pop_front();
                        check("wr_data", {32'h0, wr_data}, {32'h0, e.data});
                        check("wr_addr", wr_addr, e.addr);
                        if (e.sel >= 4)
                            check("round_trip_imm", decode_imm(e.sel, wr_data), e.imm);
                    end
                end
                prev_stall = wr_valid && !wr_ready;
                prev_data  = wr_data;
                prev_addr  = wr_addr;
            end
        end
    end

    // Issue one request; lit_en substitutes a literal expected word for the model's.
    task automatic issue(input int sel, input int rd, input int rn, input int rm,
                         input longint imm, input bit lit_en, input logic [31:0] lit);
        bit   ok;
        bit   legal;
        exp_t e;
        @(posedge clk);
        #1;
        in_sel = 4'(sel); in_rd = 5'(rd); in_rn = 5'(rn); in_rm = 5'(rm);
        in_imm = imm; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL in_ready_timeout: sel %0d never accepted", sel);
            in_valid = 1'b0;
            return;
        end
        legal = model_legal(sel, imm);
        if (legal) begin
            e.data = lit_en ? lit : model_enc(sel, rd, rn, rm, imm);
            e.addr = BASE + 64'(4 * pushed);
            e.sel  = sel;
            e.imm  = imm;
            sb.push_back(e);
            pushed++;
        end else begin
            err_exp = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!legal) begin
            @(negedge clk);
            check("reject_err", {63'h0, err}, 64'd1);
            check("reject_no_write", {63'h0, wr_valid}, 64'd0);
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL drain_timeout: %0d words still expected", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_clear();
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        pushed  = 0;
        err_exp = 1'b0;
        @(negedge clk);
        check("clear_count", {57'h0, count}, 64'd0);
        check("clear_in_ready", {63'h0, in_ready}, 64'd1);
        check("clear_err", {63'h0, err}, 64'd0);
        check("clear_addr", wr_addr, BASE);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_valid"}, {63'h0, wr_valid}, 64'd0);
        check({tag, "_wr_data"}, {32'h0, wr_data}, 64'd0);
        check({tag, "_wr_addr"}, wr_addr, BASE);
        check({tag, "_count"}, {57'h0, count}, 64'd0);
        check({tag, "_full"}, {63'h0, full}, 64'd0);
        check({tag, "_err"}, {63'h0, err}, 64'd0);
        check({tag, "_in_ready"}, {63'h0, in_ready}, 64'd1);
    endtask

    function automatic longint rand_imm();
        longint picks[16] = '{0, 4095, 4096, -256, 255, 256, -257, -4, 6,
                              (64'sd1 <<< 20) - 4, -(64'sd1 <<< 20), (64'sd1 <<< 20),
                              (64'sd1 <<< 27) - 4, -(64'sd1 <<< 27), (64'sd1 <<< 27), -1};
        longint v;
        if ($urandom_range(0, 3) == 0) return picks[$urandom_range(0, 15)];
        v = longint'({$urandom, $urandom}) >>> $urandom_range(34, 63);
        if ($urandom_range(0, 1) == 1) v = v & ~longint'(3);
        return v;
    endfunction

    initial begin
        #12;
        check_reset_values("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors with literal encodings.
        rdy_mode = 0;
        issue(0, 1, 2, 3, 0, 1'b1, 32'h8B030041);
        drain();
        check("add_count", {57'h0, count}, 64'(pushed));
        issue(6, 9, 9, 0, 4095, 1'b1, 32'h913FFD29);
        issue(6, 9, 9, 0, 4096, 1'b0, 32'h0);
        issue(9, 0, 0, 0, -4, 1'b1, 32'h17FFFFFF);
        issue(9, 0, 0, 0, 6, 1'b0, 32'h0);
        drain();

        // LDUR held under backpressure.
        rdy_mode = 2;
        issue(4, 5, 6, 0, -8, 1'b1, 32'hF85F80C5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", {63'h0, in_ready}, 64'd0);
            check("stall_wr_valid", {63'h0, wr_valid}, 64'd1);
        end
        rdy_mode = 0;
        drain();
        check("directed_err", {63'h0, err}, {63'h0, err_exp});
        check("directed_count", {57'h0, count}, 64'(pushed));
        do_clear();

        // Random rounds, each filled to DEPTH.
        for (int r = 0; r < 4; r++) begin
            rdy_mode = 1;
            while (pushed < DEP) begin
                int sel;
                sel = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
                issue(sel, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 31)), rand_imm(), 1'b0, 32'h0);
            end
            rdy_mode = 0;
            drain();
            check("fill_full", {63'h0, full}, 64'd1);
            check("fill_in_ready", {63'h0, in_ready}, 64'd0);
            check("fill_addr", wr_addr, BASE + 64'(4 * DEP));
            check("fill_count", {57'h0, count}, 64'(DEP));
            check("fill_err", {63'h0, err}, {63'h0, err_exp});
            do_clear();
        end

        // Reset asserted while a word is held.
        rdy_mode = 2;
        issue(1, 4, 5, 6, 0, 1'b0, 32'h0);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (wr_valid) begin seen = 1'b1; break; end
            end
            check("hold_before_reset", {63'h0, seen}, 64'd1);
        end
        #2 reset_n = 1'b0;
        #1;
        sb.delete();
        pushed  = 0;
        err_exp = 1'b0;
        check_reset_values("async_reset");
        @(negedge clk);
        reset_n  = 1'b1;
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        check("post_reset_no_write", {63'h0, wr_valid}, 64'd0);
        check("post_reset_count", {57'h0, count}, 64'd0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 64'h0, byte address of the first encoded word.
REQ-002 Parameter DEPTH, default 64, maximum words emitted before the block reports full.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 clear  input  1  synchronous restart; address back to BASE_ADDR, count to 0, err cleared.
REQ-006 in_valid  input  1  request holds a valid instruction description.
REQ-007 in_ready  output  1  block accepts the request this cycle.
REQ-008 in_sel  input  4  mnemonic: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 STUR, 6 ADDI, 7 SUBI, 8 CBZ, 9 B; 10-15 illegal.
REQ-009 in_rd, in_rn, in_rm  input  5 each  register fields (in_rd is Rt for LDUR/STUR/CBZ).
REQ-010 in_imm  input  64  immediate as the decode-side extender produces it (branch values are byte offsets).
REQ-011 wr_valid  output  1  wr_data/wr_addr hold an encoded word.
REQ-012 wr_ready  input  1  instruction memory accepts the word.
REQ-013 wr_data  output  32  encoded LEGv8 instruction.
REQ-014 wr_addr  output  64  byte address of wr_data.
REQ-015 count  output  7  words emitted since reset/clear.
REQ-016 full  output  1  count == DEPTH.
REQ-017 err  output  1  sticky; set by any rejected request.

Function
REQ-018 The block SHALL have states IDLE and HOLD; IDLE: in_ready = !full; HOLD: in_ready = 0, wr_valid = 1.
REQ-019 A request SHALL be accepted when in_valid && in_ready; a legal request moves IDLE->HOLD with the encoded word registered (1-cycle latency to wr_valid).
REQ-020 HOLD->IDLE SHALL occur on wr_valid && wr_ready; on that edge wr_addr += 4 and count += 1.
REQ-021 wr_data and wr_addr SHALL be stable while wr_valid && !wr_ready.
REQ-022 R-type encoding SHALL be op[31:21], Rm[20:16], shamt[15:10]=0, Rn[9:5], Rd[4:0]; op: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
REQ-023 I-type encoding SHALL be op[31:22], imm[21:10]=in_imm[11:0], Rn, Rd; op: ADDI 1001000100, SUBI 1101000100.
REQ-024 D-type encoding SHALL be op[31:21], in_imm[8:0] at [20:12], [11:10]=00, Rn, Rt; op: STUR 11111000000, LDUR 11111000010.
REQ-025 CBZ SHALL encode 10110100 at [31:24], in_imm[20:2] at [23:5], Rt at [4:0].
REQ-026 B SHALL encode 000101 at [31:26], in_imm[27:2] at [25:0].
REQ-027 Range rules SHALL be: ADDI/SUBI 0..4095; LDUR/STUR -256..255 (in_imm equals sign-extension of bits [8:0]); CBZ in_imm[1:0]=0 and in_imm equals sign-extension of [20:0]; B in_imm[1:0]=0 and in_imm equals sign-extension of [27:0]; R-type ignores in_imm.
REQ-028 An illegal in_sel or out-of-range immediate SHALL be accepted (in_ready handshake completes), set err, emit nothing, and remain in IDLE.
REQ-029 Round-trip property: for every legal request, the decode-side extension of wr_data SHALL equal in_imm.
REQ-030 When full, in_ready SHALL be 0; a word in HOLD when count reaches DEPTH-1 SHALL still complete.
REQ-031 clear SHALL take priority over all handshakes and return the block to IDLE, discarding a held word.

Reset
REQ-032 On reset_n low, immediately: state IDLE, wr_valid 0, wr_data 0, wr_addr BASE_ADDR, count 0, full 0, err 0, in_ready 1.
REQ-033 Reset asserted in HOLD SHALL drop the pending word without a write.

Verification
REQ-034 ADD rd=1 rn=2 rm=3, wr_ready=1 -> next cycle wr_data 32'h8B030041, wr_addr BASE_ADDR; then count 1.
REQ-035 ADDI rd=9 rn=9 imm=4095 -> 32'h913FFD29; imm=4096 -> err 1, no wr_valid.
REQ-036 B imm=-4 -> 32'h17FFFFFF; B imm=6 -> err 1.
REQ-037 LDUR rt=5 rn=6 imm=-8 -> 32'hF85F80C5; hold wr_ready 0 for 3 cycles -> wr_data/wr_addr stable, in_ready 0.
REQ-038 Emit DEPTH words -> full 1, in_ready 0, wr_addr BASE_ADDR+4*DEPTH; clear -> count 0, in_ready 1.
REQ-039 reset_n pulsed low mid-HOLD -> wr_valid 0 asynchronously, all outputs at REQ-032 values.
